// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 keypad scanner.
// KEYMAP translates a physical (row*4 + col) position into a CHIP-8 hex key.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_idx_t;

  localparam key_idx_t KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

  // Index of the lowest set bit; returns 0 when no bit is set.
  function automatic key_idx_t lowest_set(input logic [15:0] v);
    key_idx_t r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = key_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus the debounced key state handed to the CPU.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keypad_matrix;
  logic        key_down;
  key_idx_t    key_down_index;

  modport master (
    output row_n,
    output keypad_matrix,
    output key_down,
    output key_down_index,
    input  col_n
  );

  modport slave (
    input  row_n,
    input  keypad_matrix,
    input  key_down,
    input  key_down_index,
    output col_n
  );

endinterface

// File: rtl/keypad_scan_sync2.sv
// Generic two-flop synchronizer; both stages reset to all-ones so that
// pulled-up, active-low inputs read as idle during reset.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: drives one row low at a time, debounces whole frames
// and publishes a stable CHIP-8 ordered key matrix with a press pulse.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 256,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         reset,
  keypad_scan_if.master kif
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

  logic [3:0]    col_sync;

  logic [1:0]    row_sel_q, row_sel_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0]   frame_q, frame_d;
  logic [15:0]   cand_q, cand_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          update_q, update_d;
  logic [15:0]   matrix_q, matrix_d;
  logic          key_down_q, key_down_d;
  key_idx_t      key_idx_q, key_idx_d;

  logic [15:0]   newly;
  logic [3:0]    phys;

  sync2 #(.WIDTH(COLS)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kif.col_n),
    .q     (col_sync)
  );

  // Sampling happens at the end of each row dwell; the row-3 sample closes a
  // frame, and any matrix change is applied one cycle later from cand_q.
  always_comb begin
    row_sel_d  = row_sel_q;
    dwell_d    = dwell_q;
    frame_d    = frame_q;
    cand_d     = cand_q;
    stable_d   = stable_q;
    update_d   = 1'b0;
    matrix_d   = matrix_q;
    key_down_d = 1'b0;
    key_idx_d  = key_idx_q;
    newly      = cand_q & ~matrix_q;
    phys       = '0;

    if (dwell_q == DWELL_LAST) begin
      dwell_d   = '0;
      row_sel_d = row_sel_q + 2'd1;
      for (int c = 0; c < COLS; c++) begin
        phys = {row_sel_q, c[1:0]};
        frame_d[KEYMAP[phys]] = ~col_sync[c];
      end

      if (row_sel_q == 2'(ROWS - 1)) begin
        if (frame_d == cand_q) begin
          stable_d = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
        end else begin
          cand_d   = frame_d;
          stable_d = SW'(1);
        end
        update_d = (stable_d == STABLE_MAX) && (cand_d != matrix_q);
      end
    end else begin
      dwell_d = dwell_q + 1'b1;
    end

    if (update_q) begin
      matrix_d = cand_q;
      if (newly != '0) begin
        key_down_d = 1'b1;
        key_idx_d  = lowest_set(newly);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_sel_q  <= '0;
      dwell_q    <= '0;
      frame_q    <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      update_q   <= 1'b0;
      matrix_q   <= '0;
      key_down_q <= 1'b0;
      key_idx_q  <= '0;
    end else begin
      row_sel_q  <= row_sel_d;
      dwell_q    <= dwell_d;
      frame_q    <= frame_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      update_q   <= update_d;
      matrix_q   <= matrix_d;
      key_down_q <= key_down_d;
      key_idx_q  <= key_idx_d;
    end
  end

  assign kif.row_n          = ~(4'b0001 << row_sel_q);
  assign kif.keypad_matrix  = matrix_q;
  assign kif.key_down       = key_down_q;
  assign kif.key_down_index = key_idx_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural keypad model driving col_n.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pressed;
  logic [3:0]  col_model;

  int          vectors = 0;
  int          miscompares = 0;
  int          pulse_cnt = 0;
  logic [3:0]  last_idx = 4'h0;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  // Pressed physical key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_model = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (kif.row_n[r] == 1'b0 && pressed[r*4+c]) col_model[c] = 1'b0;
      end
    end
  end
  assign kif.col_n = col_model;

  always @(negedge clk) begin
    if (kif.key_down === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      last_idx  = kif.key_down_index;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_matrix(input logic [15:0] exp, input int budget, output int cycles);
    cycles = 0;
    while (kif.keypad_matrix !== exp && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    int base;
    reset   = 1'b1;
    pressed = 16'h0000;
    repeat (3) tick();
    vectors++;
    if (kif.row_n !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL reset_row_n: got %b expected %b", kif.row_n, 4'b1110);
    end
    vectors++;
    if (kif.keypad_matrix !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_matrix: got %h expected %h", kif.keypad_matrix, 16'h0000);
    end
    vectors++;
    if (kif.key_down !== 1'b0 || kif.key_down_index !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_key_down: got %b/%h expected 0/0", kif.key_down, kif.key_down_index);
    end
    reset = 1'b0;

    pressed = 16'h0001;
    wait_matrix(16'h0002, 3 * FRAME + 3, cyc);
    vectors++;
    if (kif.keypad_matrix !== 16'h0002) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_press: got %h expected %h", kif.keypad_matrix, 16'h0002);
    end

    cyc = 0;
    while (kif.row_n === 4'b1110 && cyc < FRAME) begin
      tick();
      cyc++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (kif.row_n !== 4'b1110 || kif.keypad_matrix !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL midscan_reset: got row_n=%b matrix=%h expected 1110/0000",
               kif.row_n, kif.keypad_matrix);
    end
    pressed = 16'h0000;
    base = pulse_cnt;
    repeat (3) tick();
    vectors++;
    if (pulse_cnt !== base) begin
      miscompares++;
      $display("[TB] FAIL pulse_during_reset: got %0d pulses expected 0", pulse_cnt - base);
    end
    reset = 1'b0;
    repeat (3 * FRAME + 4) tick();
    vectors++;
    if (pulse_cnt !== base || kif.keypad_matrix !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got pulses=%0d matrix=%h expected 0/0000",
               pulse_cnt - base, kif.keypad_matrix);
    end
  endtask

  task automatic test_single_press();
    int cyc;
    int base;
    base    = pulse_cnt;
    pressed = 16'h0040;
    wait_matrix(16'h0040, 3 * FRAME + 3, cyc);
    vectors++;
    if (kif.keypad_matrix !== 16'h0040) begin
      miscompares++;
      $display("[TB] FAIL single_press_matrix: got %h expected %h", kif.keypad_matrix, 16'h0040);
    end
    repeat (2) tick();
    vectors++;
    if (pulse_cnt - base !== 1 || last_idx !== 4'h6) begin
      miscompares++;
      $display("[TB] FAIL single_press_pulse: got %0d pulses idx %h expected 1 idx 6",
               pulse_cnt - base, last_idx);
    end
    pressed = 16'h0000;
    wait_matrix(16'h0000, 4 * FRAME, cyc);
    vectors++;
    if (kif.keypad_matrix !== 16'h0000 || pulse_cnt - base !== 1) begin
      miscompares++;
      $display("[TB] FAIL single_release: got matrix=%h pulses=%0d expected 0000/1",
               kif.keypad_matrix, pulse_cnt - base);
    end
  endtask

  task automatic test_bounce();
    int base;
    base = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? 16'h2000 : 16'h0000;
      repeat (FRAME) tick();
      vectors++;
      if (kif.keypad_matrix !== 16'h0000) begin
        miscompares++;
        $display("[TB] FAIL bounce_matrix_%0d: got %h expected %h", i, kif.keypad_matrix, 16'h0000);
      end
    end
    pressed = 16'h0000;
    repeat (3 * FRAME) tick();
    vectors++;
    if (kif.keypad_matrix !== 16'h0000 || pulse_cnt !== base) begin
      miscompares++;
      $display("[TB] FAIL bounce_settle: got matrix=%h pulses=%0d expected 0000/0",
               kif.keypad_matrix, pulse_cnt - base);
    end
  endtask

  task automatic test_multi_key();
    int cyc;
    int base;
    base    = pulse_cnt;
    pressed = 16'h8008;
    wait_matrix(16'h9000, 4 * FRAME, cyc);
    vectors++;
    if (kif.keypad_matrix !== 16'h9000) begin
      miscompares++;
      $display("[TB] FAIL multi_matrix: got %h expected %h", kif.keypad_matrix, 16'h9000);
    end
    repeat (2 * FRAME) tick();
    vectors++;
    if (pulse_cnt - base !== 1 || last_idx !== 4'hC) begin
      miscompares++;
      $display("[TB] FAIL multi_pulse: got %0d pulses idx %h expected 1 idx C",
               pulse_cnt - base, last_idx);
    end
    pressed = 16'h0000;
    wait_matrix(16'h0000, 4 * FRAME, cyc);
    vectors++;
    if (kif.keypad_matrix !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL multi_release: got %h expected %h", kif.keypad_matrix, 16'h0000);
    end
  endtask

  task automatic test_held_addition();
    int cyc;
    int base;
    base    = pulse_cnt;
    pressed = 16'h0020;
    wait_matrix(16'h0020, 3 * FRAME + 3, cyc);
    vectors++;
    if (kif.keypad_matrix !== 16'h0020) begin
      miscompares++;
      $display("[TB] FAIL held_first_matrix: got %h expected %h", kif.keypad_matrix, 16'h0020);
    end
    repeat (2 * FRAME) tick();
    vectors++;
    if (pulse_cnt - base !== 1 || last_idx !== 4'h5) begin
      miscompares++;
      $display("[TB] FAIL held_first_pulse: got %0d pulses idx %h expected 1 idx 5",
               pulse_cnt - base, last_idx);
    end
    pressed = 16'h1020;
    wait_matrix(16'h0420, 3 * FRAME + 3, cyc);
    vectors++;
    if (kif.keypad_matrix !== 16'h0420) begin
      miscompares++;
      $display("[TB] FAIL held_add_matrix: got %h expected %h", kif.keypad_matrix, 16'h0420);
    end
    repeat (2) tick();
    vectors++;
    if (pulse_cnt - base !== 2 || last_idx !== 4'hA) begin
      miscompares++;
      $display("[TB] FAIL held_add_pulse: got %0d pulses idx %h expected 2 idx A",
               pulse_cnt - base, last_idx);
    end
    pressed = 16'h0000;
    wait_matrix(16'h0000, 4 * FRAME, cyc);
  endtask

  task automatic test_row_sequencing();
    int cyc;
    logic [3:0] exp_row;
    logic [3:0] low_bits;
    cyc = 0;
    while (kif.row_n !== 4'b0111 && cyc < FRAME) begin
      tick();
      cyc++;
    end
    while (kif.row_n !== 4'b1110 && cyc < 2 * FRAME) begin
      tick();
      cyc++;
    end
    vectors++;
    if (kif.row_n !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL row_align: got %b expected %b", kif.row_n, 4'b1110);
    end
    for (int i = 0; i < 16; i++) begin
      exp_row  = ~(4'b0001 << (i / 4));
      low_bits = ~kif.row_n;
      vectors++;
      if (kif.row_n !== exp_row || $countones(low_bits) != 1) begin
        miscompares++;
        $display("[TB] FAIL row_seq_%0d: got %b expected %b", i, kif.row_n, exp_row);
      end
      tick();
    end
    vectors++;
    if (kif.row_n !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL row_wrap: got %b expected %b", kif.row_n, 4'b1110);
    end
  endtask

  initial begin
    reset   = 1'b1;
    pressed = 16'h0000;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_held_addition();
    test_row_sequencing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
